// File: rtl/vx_tag_flush_ctrl.sv
// Per-bank tag-store invalidation sequencer: walks every line issuing one
// flush write per line after reset and on each accepted full-flush request.
module vx_tag_flush_ctrl #(
  parameter int CACHE_ID       = 0,
  parameter int BANK_ID        = 0,
  parameter int LINES_PER_BANK = 64,
  localparam int LINE_SEL_BITS = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_req_valid,
  output logic                     flush_req_ready,
  input  logic                     pipe_idle,
  input  logic                     stall,
  output logic                     flush,
  output logic [LINE_SEL_BITS-1:0] flush_addr,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRAIN,
    S_WALK,
    S_DONE
  } state_t;

  localparam logic [LINE_SEL_BITS-1:0] LAST_IDX = LINE_SEL_BITS'(LINES_PER_BANK - 1);

  state_t                   state_q, state_d;
  logic [LINE_SEL_BITS-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      // Pipeline is empty out of reset, so the first walk skips the drain.
      S_INIT: begin
        state_d = S_WALK;
        idx_d   = '0;
      end
      S_IDLE: begin
        if (flush_req_valid) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        if (pipe_idle) state_d = S_WALK;
      end
      S_WALK: begin
        if (!stall) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + LINE_SEL_BITS'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_INIT;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    flush           = (state_q == S_WALK);
    flush_addr      = idx_q;
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
    flush_req_ready = (state_q == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset && state_q == S_DONE)
      assert (idx_q == LAST_IDX)
        else $error("tag flush cache %0d bank %0d: walk ended off the last line", CACHE_ID, BANK_ID);
  end

endmodule

// File: tb/tb_vx_tag_flush_ctrl.sv
// Bench for vx_tag_flush_ctrl: per-cycle vector tables for L=8 and L=1 plus a
// randomly stalled walk checked against an address scoreboard.
module tb_vx_tag_flush_ctrl;

  typedef struct {
    logic        rst;
    logic        req;
    logic        pi;
    logic        st;
    logic        f;
    int unsigned a;
    logic        b;
    logic        d;
    logic        r;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset8 = 1'b0, req8 = 1'b0, pi8 = 1'b0, st8 = 1'b0;
  logic       flush8, busy8, done8, ready8;
  logic [2:0] addr8;
  logic       reset1 = 1'b0, req1 = 1'b0, pi1 = 1'b0, st1 = 1'b0;
  logic       flush1, busy1, done1, ready1;
  logic [0:0] addr1;

  vx_tag_flush_ctrl #(.CACHE_ID(0), .BANK_ID(0), .LINES_PER_BANK(8)) dut8 (
    .clk(clk), .reset(reset8), .flush_req_valid(req8), .flush_req_ready(ready8),
    .pipe_idle(pi8), .stall(st8), .flush(flush8), .flush_addr(addr8),
    .busy(busy8), .done(done8)
  );

  vx_tag_flush_ctrl #(.CACHE_ID(0), .BANK_ID(1), .LINES_PER_BANK(1)) dut1 (
    .clk(clk), .reset(reset1), .flush_req_valid(req1), .flush_req_ready(ready1),
    .pipe_idle(pi1), .stall(st1), .flush(flush1), .flush_addr(addr1),
    .busy(busy1), .done(done1)
  );

  vec_t        v8[$];
  vec_t        v1[$];
  vec_t        sb[$];
  int unsigned exp_a[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s rec %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic rec(input int w, input logic rst, input logic req, input logic pi, input logic st,
                     input logic f, input int unsigned a, input logic b, input logic d, input logic r);
    vec_t v;
    v = '{rst: rst, req: req, pi: pi, st: st, f: f, a: a, b: b, d: d, r: r};
    if (w == 8) v8.push_back(v);
    else        v1.push_back(v);
  endtask

  task automatic t_init(input int w, input logic rst);
    rec(w, rst, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic t_idle(input int w, input logic req, input logic pi);
    rec(w, 1'b1, req, pi, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic t_drain(input int w, input logic pi);
    rec(w, 1'b1, 1'b0, pi, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic t_walk(input int w, input int unsigned a, input logic st, input logic req);
    rec(w, 1'b1, req, 1'b0, st, 1'b1, a, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic t_done(input int w, input int unsigned last, input logic req);
    rec(w, 1'b1, req, 1'b0, 1'b0, 1'b0, last, 1'b1, 1'b1, 1'b0);
  endtask

  // Drive one cycle of stimulus, then check outputs of the current state.
  task automatic apply(input int w, input int idx, input vec_t v);
    vec_t e;
    if (w == 8) begin
      reset8 = v.rst; req8 = v.req; pi8 = v.pi; st8 = v.st;
    end else begin
      reset1 = v.rst; req1 = v.req; pi1 = v.pi; st1 = v.st;
    end
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    if (w == 8) begin
      chk("l8_flush", idx, int'(flush8), int'(e.f));
      chk("l8_addr",  idx, int'(addr8),  int'(e.a));
      chk("l8_busy",  idx, int'(busy8),  int'(e.b));
      chk("l8_done",  idx, int'(done8),  int'(e.d));
      chk("l8_ready", idx, int'(ready8), int'(e.r));
    end else begin
      chk("l1_flush", idx, int'(flush1), int'(e.f));
      chk("l1_addr",  idx, int'(addr1),  int'(e.a));
      chk("l1_busy",  idx, int'(busy1),  int'(e.b));
      chk("l1_done",  idx, int'(done1),  int'(e.d));
      chk("l1_ready", idx, int'(ready1), int'(e.r));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic got_done;

    // L=8: reset walk
    t_init(8, 1'b0); t_init(8, 1'b0); t_init(8, 1'b1);
    for (int unsigned a = 0; a < 8; a++) t_walk(8, a, 1'b0, 1'b0);
    t_done(8, 7, 1'b0); t_idle(8, 1'b0, 1'b0); t_idle(8, 1'b0, 1'b0);
    // requested walk, 3-cycle stall at addr 4
    t_idle(8, 1'b1, 1'b1); t_drain(8, 1'b1);
    for (int unsigned a = 0; a < 4; a++) t_walk(8, a, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) t_walk(8, 4, 1'b1, 1'b0);
    for (int unsigned a = 4; a < 8; a++) t_walk(8, a, 1'b0, 1'b0);
    t_done(8, 7, 1'b0); t_idle(8, 1'b0, 1'b0);
    // drain wait, pipe busy for 5 cycles
    t_idle(8, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) t_drain(8, 1'b0);
    t_drain(8, 1'b1);
    for (int unsigned a = 0; a < 8; a++) t_walk(8, a, 1'b0, 1'b0);
    t_done(8, 7, 1'b0); t_idle(8, 1'b0, 1'b0);
    // request raised during a reset walk, held until accepted
    t_init(8, 1'b0); t_init(8, 1'b1);
    t_walk(8, 0, 1'b0, 1'b0); t_walk(8, 1, 1'b0, 1'b0);
    for (int unsigned a = 2; a < 8; a++) t_walk(8, a, 1'b0, 1'b1);
    t_done(8, 7, 1'b1); t_idle(8, 1'b1, 1'b1); t_drain(8, 1'b1);
    for (int unsigned a = 0; a < 8; a++) t_walk(8, a, 1'b0, 1'b0);
    t_done(8, 7, 1'b0); t_idle(8, 1'b0, 1'b0);
    // reset asserted mid-walk at addr 5
    t_idle(8, 1'b1, 1'b1); t_drain(8, 1'b1);
    for (int unsigned a = 0; a < 6; a++) t_walk(8, a, 1'b0, 1'b0);
    t_init(8, 1'b0); t_init(8, 1'b0); t_init(8, 1'b1);
    for (int unsigned a = 0; a < 8; a++) t_walk(8, a, 1'b0, 1'b0);
    t_done(8, 7, 1'b0); t_idle(8, 1'b0, 1'b0);

    // L=1: reset walk then requested walk with one stall cycle
    t_init(1, 1'b0); t_init(1, 1'b1);
    t_walk(1, 0, 1'b0, 1'b0); t_done(1, 0, 1'b0); t_idle(1, 1'b0, 1'b0);
    t_idle(1, 1'b1, 1'b1); t_drain(1, 1'b1);
    t_walk(1, 0, 1'b1, 1'b0); t_walk(1, 0, 1'b0, 1'b0);
    t_done(1, 0, 1'b0); t_idle(1, 1'b0, 1'b0);

    @(negedge clk);
    foreach (v8[i]) apply(8, i, v8[i]);

    // Randomly stalled walk: every taken write must match the next expected address.
    req8 = 1'b1; pi8 = 1'b1; st8 = 1'b0;
    for (int unsigned a = 0; a < 8; a++) exp_a.push_back(a);
    #1 chk("rs_accept_ready", 0, int'(ready8), 1);
    @(negedge clk);
    req8 = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      st8 = 1'($urandom_range(0, 1));
      #1;
      if (done8) begin
        got_done = 1'b1;
      end else if (flush8 && !st8) begin
        if (exp_a.size() == 0) chk("rs_extra_write", c, int'(addr8), -1);
        else                   chk("rs_addr", c, int'(addr8), int'(exp_a.pop_front()));
      end
      @(negedge clk);
    end
    st8 = 1'b0;
    chk("rs_done_seen", 0, int'(got_done), 1);
    chk("rs_writes_left", 0, exp_a.size(), 0);
    #1;
    chk("rs_idle_ready", 0, int'(ready8), 1);
    chk("rs_idle_done", 0, int'(done8), 0);
    @(negedge clk);

    foreach (v1[i]) apply(1, i, v1[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
